noc_credit_rx_port: RTL and testbench

//  Receive end of the credit-based flit link driven by a processor element. The sender

---
 rtl/noc_credit_rx_port.sv | 171 +++++++++++++++++
 tb/tb_noc_credit_rx_port.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/noc_credit_rx_port.sv
// noc_credit_rx_port
// Receive side of a credit-based flit link. Arriving flits are buffered in a
// small FIFO and offered to the router core with valid/ready. Each drained flit
// returns one credit pulse to the sender. Packet framing is checked on every
// accepted flit. Overflow and framing problems set sticky error flags.
module noc_credit_rx_port #(
    parameter int DATA_W = 20,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [DATA_W-1:0] datain,
    input  logic              in_valid,
    output logic              co,
    output logic [DATA_W-1:0] dataout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PTR_W:0]    count,
    output logic              ovf_err,
    output logic              pkt_err,
    input  logic              err_clr
);

    // Flit type encodings carried in the two top bits of every flit
    localparam logic [1:0] FT_BODY   = 2'b00;
    localparam logic [1:0] FT_HEAD   = 2'b01;
    localparam logic [1:0] FT_TAIL   = 2'b10;
    localparam logic [1:0] FT_SINGLE = 2'b11;

    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_INPKT = 1'b1
    } frame_state_t;

    // Extract the framing type field of a flit
    function automatic logic [1:0] flit_type(input logic [DATA_W-1:0] flit);
        return flit[DATA_W-1:DATA_W-2];
    endfunction

    // Advance a ring pointer, wrapping after the last entry
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_LAST) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + PTR_W'(1);
        end
        return nxt;
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              out_valid_q, out_valid_d;
    logic              co_q, co_d;
    logic              ovf_err_q, ovf_err_d;
    logic              pkt_err_q, pkt_err_d;
    frame_state_t      state_q, state_d;
    logic              push_s, pop_s, frame_err_s;

    // Handshake decode, pointer/occupancy update, framing check and error flags
    always_comb begin
        pop_s       = out_valid_q && out_ready;
        push_s      = in_valid && ((count_q < DEPTH_CNT) || pop_s);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        state_d     = state_q;
        frame_err_s = 1'b0;

        if (push_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase

        // Framing only looks at flits that were actually stored
        if (push_s) begin
            case (state_q)
                ST_IDLE: begin
                    case (flit_type(datain))
                        FT_HEAD:   state_d = ST_INPKT;
                        FT_SINGLE: state_d = ST_IDLE;
                        default: begin
                            state_d     = ST_IDLE;
                            frame_err_s = 1'b1;
                        end
                    endcase
                end
                ST_INPKT: begin
                    case (flit_type(datain))
                        FT_BODY:   state_d = ST_INPKT;
                        FT_TAIL:   state_d = ST_IDLE;
                        FT_HEAD: begin
                            state_d     = ST_INPKT;
                            frame_err_s = 1'b1;
                        end
                        default: begin
                            state_d     = ST_IDLE;
                            frame_err_s = 1'b1;
                        end
                    endcase
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end

        out_valid_d = (count_d != (PTR_W+1)'(0));
        co_d        = pop_s;
        // A new error in the same cycle as err_clr keeps the flag set
        ovf_err_d   = (ovf_err_q && !err_clr) || (in_valid && !push_s);
        pkt_err_d   = (pkt_err_q && !err_clr) || frame_err_s;
    end

    // Control state registers, cleared by the asynchronous reset
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {(PTR_W+1){1'b0}};
            out_valid_q <= 1'b0;
            co_q        <= 1'b0;
            ovf_err_q   <= 1'b0;
            pkt_err_q   <= 1'b0;
            state_q     <= ST_IDLE;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            co_q        <= co_d;
            ovf_err_q   <= ovf_err_d;
            pkt_err_q   <= pkt_err_d;
            state_q     <= state_d;
        end
    end

    // Flit storage; contents survive reset and are qualified by out_valid
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= datain;
        end
    end

    assign dataout   = mem_q[rd_ptr_q];
    assign out_valid = out_valid_q;
    assign co        = co_q;
    assign count     = count_q;
    assign ovf_err   = ovf_err_q;
    assign pkt_err   = pkt_err_q;

endmodule

// File: tb/tb_noc_credit_rx_port.sv
// Directed bench for noc_credit_rx_port: reset, fill/drain, full-boundary
// behaviour, streaming across pointer wrap with credit counting, and framing.
module tb_noc_credit_rx_port;

    logic        clk;
    logic        RST;
    logic [19:0] datain;
    logic        in_valid;
    logic        co;
    logic [19:0] dataout;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  count;
    logic        ovf_err;
    logic        pkt_err;
    logic        err_clr;

    int n_asserts = 0;
    int n_fails   = 0;

    noc_credit_rx_port #(.DATA_W(20), .DEPTH(4), .PTR_W(2)) dut (
        .clk       (clk),
        .RST       (RST),
        .datain    (datain),
        .in_valid  (in_valid),
        .co        (co),
        .dataout   (dataout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .ovf_err   (ovf_err),
        .pkt_err   (pkt_err),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs settle 1ns after the edge, outputs sampled there too
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [19:0] f;
        int          co_cnt;

        RST = 1'b0; datain = 20'h0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
        step(); step();
        RST = 1'b1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_co", 32'(co), 32'd0);

        // Traffic with a framing error, then an asynchronous reset mid-packet
        in_valid = 1'b1; datain = 20'h0_0AAA; step();
        chk("pre_pkt_err", 32'(pkt_err), 32'd1);
        datain = 20'h4_0BBB; step();
        chk("pre_count", 32'(count), 32'd2);
        in_valid = 1'b0;
        RST = 1'b0; #2;
        chk("t1_count", 32'(count), 32'd0);
        chk("t1_valid", 32'(out_valid), 32'd0);
        chk("t1_co", 32'(co), 32'd0);
        chk("t1_ovf", 32'(ovf_err), 32'd0);
        chk("t1_pkt", 32'(pkt_err), 32'd0);
        step();
        RST = 1'b1;

        // Fill with a well-formed packet, core not ready
        in_valid = 1'b1;
        datain = 20'h4_0001; step(); chk("t2_co_a", 32'(co), 32'd0);
        datain = 20'h0_0002; step(); chk("t2_co_b", 32'(co), 32'd0);
        datain = 20'h0_0003; step(); chk("t2_co_c", 32'(co), 32'd0);
        datain = 20'h8_0004; step(); chk("t2_co_d", 32'(co), 32'd0);
        in_valid = 1'b0;
        chk("t2_count", 32'(count), 32'd4);
        chk("t2_pkt", 32'(pkt_err), 32'd0);
        chk("t2_ovf", 32'(ovf_err), 32'd0);
        chk("t2_valid", 32'(out_valid), 32'd1);

        // Single-cycle pop from full
        out_ready = 1'b1;
        chk("t3_head", 32'(dataout), 32'h4_0001);
        step();
        out_ready = 1'b0;
        chk("t3_co", 32'(co), 32'd1);
        chk("t3_count", 32'(count), 32'd3);
        chk("t3_next", 32'(dataout), 32'h0_0002);
        step();
        chk("t3_co_off", 32'(co), 32'd0);

        // Refill, then push and pop together while full
        in_valid = 1'b1; datain = 20'hC_0005; step();
        chk("t4_full", 32'(count), 32'd4);
        datain = 20'h4_0006; out_ready = 1'b1; step();
        chk("t4_pp_count", 32'(count), 32'd4);
        chk("t4_pp_co", 32'(co), 32'd1);
        chk("t4_pp_ovf", 32'(ovf_err), 32'd0);
        chk("t4_pp_head", 32'(dataout), 32'h0_0003);
        // Full with no pop: dropped, not framed
        datain = 20'h4_0007; out_ready = 1'b0; step();
        in_valid = 1'b0;
        chk("t4_ovf", 32'(ovf_err), 32'd1);
        chk("t4_ovf_count", 32'(count), 32'd4);
        chk("t4_ovf_co", 32'(co), 32'd0);
        chk("t4_ovf_pkt", 32'(pkt_err), 32'd0);
        // Drain and confirm the dropped flit never entered
        out_ready = 1'b1;
        chk("t4_d0", 32'(dataout), 32'h0_0003); step();
        chk("t4_d1", 32'(dataout), 32'h8_0004); step();
        chk("t4_d2", 32'(dataout), 32'hC_0005); step();
        chk("t4_d3", 32'(dataout), 32'h4_0006); step();
        chk("t4_empty", 32'(count), 32'd0);
        chk("t4_empty_v", 32'(out_valid), 32'd0);
        step();
        chk("t4_empty_co", 32'(co), 32'd0);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk("t4_ovf_clr", 32'(ovf_err), 32'd0);

        // Stream ten flits (packet continues BODY..., ends with TAIL)
        co_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            in_valid = (i < 10);
            f = (i < 9) ? (20'h0_0010 + 20'(i)) : 20'h8_0019;
            datain = f;
            step();
            if (co) co_cnt++;
            if (i < 10) begin
                chk("t5_data", 32'(dataout), 32'(f));
                chk("t5_count", 32'(count), 32'd1);
            end
        end
        in_valid = 1'b0;
        chk("t5_credits", 32'(co_cnt), 32'd10);
        chk("t5_count_end", 32'(count), 32'd0);
        chk("t5_pkt", 32'(pkt_err), 32'd0);

        // Framing: BODY while idle, clear, HEAD after HEAD, error beats clear
        in_valid = 1'b1; datain = 20'h0_0020; step();
        in_valid = 1'b0;
        chk("t6_body_idle", 32'(pkt_err), 32'd1);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk("t6_clr", 32'(pkt_err), 32'd0);
        in_valid = 1'b1; datain = 20'h4_0021; step();
        chk("t6_head_ok", 32'(pkt_err), 32'd0);
        datain = 20'h4_0022; step();
        chk("t6_head_head", 32'(pkt_err), 32'd1);
        datain = 20'hC_0023; err_clr = 1'b1; step();
        chk("t6_err_wins", 32'(pkt_err), 32'd1);
        in_valid = 1'b0; step();
        err_clr = 1'b0;
        chk("t6_clr2", 32'(pkt_err), 32'd0);
        step(); step(); step();
        chk("t6_drained", 32'(count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
